partition_sweep_err: RTL and testbench
======================================

# partition_sweep_err

Exhaustive sweep-and-score engine for one approximated multiplier partition, such as the 7-input/4-output slice of mult16. It enumerates every input vector 0..2^NI-1 on a shared bus that drives both the exact partition and its approximated replacement. After each vector settles it samples both output words. It accumulates mismatch, Hamming and absolute-value error metrics and signals completion with a done pulse. It sits directly downstream of the partition netlists and feeds the per-partition error budget used by the approximation loop.

## Interface
- NI, 7: partition input count; the sweep covers 2^NI vectors.
- NO, 4: partition output count.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begins a sweep; sampled only in IDLE.
- pi_out  out  NI  current input vector, wired to both partitions; bit order matches partition port order, MSB first.
- po_exact  in  NO  exact partition outputs; combinational response to pi_out.
- po_approx  in  NO  approximate partition outputs; combinational response to pi_out.
- busy  out  1  high in APPLY and CAPTURE.
- done  out  1  one-cycle pulse in FINISH.
- mismatch_cnt  out  NI+1  count of vectors where po_exact != po_approx.
- hamming_sum  out  NI+clog2(NO+1)  sum of popcount(po_exact ^ po_approx).
- abs_err_sum  out  NI+NO  sum of |po_exact - po_approx|, with outputs treated as unsigned.
- max_abs_err  out  NO  maximum |po_exact - po_approx| seen in the sweep.

## Operation
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE.
- States:
  - IDLE: busy=0, done=0; results hold. If start=1 at the edge: clear all accumulators, pi_out<=0, go to APPLY.
  - APPLY: one settle cycle with pi_out stable; go to CAPTURE.
  - CAPTURE: at the edge, fold in the current po_exact/po_approx:
    - mismatch_cnt += (diff != 0)
    - hamming_sum += popcount(xor)
    - abs_err_sum += |diff|
    - max_abs_err = max(max_abs_err, |diff|)
    - If pi_out == all-ones, go to FINISH; otherwise pi_out++ and go to APPLY.
  - FINISH: done=1, busy=0; pi_out holds all-ones. Go to IDLE next edge.
- Width rules:
  - |diff| is computed NO+1 bits wide, then reduced to NO bits.
  - Accumulator widths are sized so no overflow is possible; no saturation logic.
  - pi_out never wraps during a sweep; the terminal vector is detected explicitly.
- Boundary conditions:
  - start in APPLY, CAPTURE or FINISH is ignored; no restart and no queueing.
  - Results stay stable from FINISH until the next accepted start, which clears them at that edge.
  - rst mid-sweep returns all outputs to 0 and the state to IDLE immediately. No partial done is produced.
  - po_* inputs are ignored outside CAPTURE.

## Timing
- Two cycles per vector.
- With start accepted at edge 0, vector k is captured at edge 2k+2.
- The last capture is at edge 2^(NI+1). done is high in the cycle after it; results are final in that same cycle.
- For NI=7: done follows edge 256. Back-to-back sweeps with start held high repeat every 2^(NI+1)+2 = 258 cycles.
- busy rises after edge 0 and falls after edge 2^(NI+1).
- Both partitions must settle within one clock period; only pi_out is registered.

## Test plan
- Approx identical to exact (po = pi[3:0]+pi[6:4]): done after 256 cycles; all four metrics 0; done high exactly one cycle.
- po_approx = po_exact ^ 4'b0001: mismatch_cnt=128, hamming_sum=128, abs_err_sum=128, max_abs_err=1.
- po_exact = pi[3:0], po_approx = 0: mismatch_cnt=120, hamming_sum=256, abs_err_sum=960, max_abs_err=15.
- Single fault, approx flips bit 3 only when pi=7'h7F: mismatch_cnt=1, hamming_sum=1, abs_err_sum=8, max_abs_err=8; done still arrives at cycle 256.
- Assert rst at cycle 100 of a sweep: outputs 0 and busy=0 within the same cycle with no clock edge; no done. A fresh start then yields correct results.
- Hold start high for 600 cycles: done pulses at cycles 256 and 514; start pulses during busy have no effect; results clear at each accepted start.

Source files
------------

// File: rtl/partition_sweep_err.sv
// Exhaustive sweep-and-score engine: walks every input vector of one partition,
// comparing exact and approximate outputs and accumulating error metrics.
module partition_sweep_err #(
    parameter int unsigned NI = 7,
    parameter int unsigned NO = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic [NI-1:0]                 pi_out,
    input  logic [NO-1:0]                 po_exact,
    input  logic [NO-1:0]                 po_approx,
    output logic                          busy,
    output logic                          done,
    output logic [NI:0]                   mismatch_cnt,
    output logic [NI+$clog2(NO+1)-1:0]    hamming_sum,
    output logic [NI+NO-1:0]              abs_err_sum,
    output logic [NO-1:0]                 max_abs_err
);

    localparam int unsigned MW  = NI + 1;
    localparam int unsigned PCW = $clog2(NO + 1);
    localparam int unsigned HW  = NI + PCW;
    localparam int unsigned AW  = NI + NO;
    localparam int unsigned DW  = NO + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_CAPTURE = 2'd2,
        S_FINISH  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [NI-1:0]     pi_q, pi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [MW-1:0]     mismatch_q, mismatch_d;
    logic [HW-1:0]     hamming_q, hamming_d;
    logic [AW-1:0]     abs_sum_q, abs_sum_d;
    logic [NO-1:0]     max_err_q, max_err_d;

    logic [NO-1:0]     xor_w;
    logic [DW-1:0]     diff_w;
    logic [NO-1:0]     abs_err_w;
    logic [PCW-1:0]    pop_w;

    // Per-vector error terms; only folded into the sums in CAPTURE.
    always_comb begin
        xor_w     = po_exact ^ po_approx;
        diff_w    = DW'(po_exact) - DW'(po_approx);
        abs_err_w = diff_w[NO] ? NO'(-diff_w) : NO'(diff_w);
        pop_w     = '0;
        for (int i = 0; i < int'(NO); i++) begin
            pop_w = pop_w + PCW'(xor_w[i]);
        end
    end

    always_comb begin
        state_d    = state_q;
        pi_d       = pi_q;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        mismatch_d = mismatch_q;
        hamming_d  = hamming_q;
        abs_sum_d  = abs_sum_q;
        max_err_d  = max_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mismatch_d = '0;
                    hamming_d  = '0;
                    abs_sum_d  = '0;
                    max_err_d  = '0;
                    pi_d       = '0;
                    busy_d     = 1'b1;
                    state_d    = S_APPLY;
                end
            end
            S_APPLY: begin
                busy_d  = 1'b1;
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                mismatch_d = mismatch_q + MW'(|xor_w);
                hamming_d  = hamming_q + HW'(pop_w);
                abs_sum_d  = abs_sum_q + AW'(abs_err_w);
                if (abs_err_w > max_err_q) begin
                    max_err_d = abs_err_w;
                end
                // Terminal vector detected explicitly so pi never wraps.
                if (pi_q == '1) begin
                    done_d  = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    pi_d    = pi_q + NI'(1);
                    busy_d  = 1'b1;
                    state_d = S_APPLY;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pi_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mismatch_q <= '0;
            hamming_q  <= '0;
            abs_sum_q  <= '0;
            max_err_q  <= '0;
        end else begin
            state_q    <= state_d;
            pi_q       <= pi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mismatch_q <= mismatch_d;
            hamming_q  <= hamming_d;
            abs_sum_q  <= abs_sum_d;
            max_err_q  <= max_err_d;
        end
    end

    assign pi_out       = pi_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mismatch_cnt = mismatch_q;
    assign hamming_sum  = hamming_q;
    assign abs_err_sum  = abs_sum_q;
    assign max_abs_err  = max_err_q;

endmodule

// File: tb/tb_partition_sweep_err.sv
// Directed bench for partition_sweep_err: table of partition models with
// hand-computed sweep metrics, plus reset and held-start sequences.
module tb_partition_sweep_err;

    localparam int unsigned NI = 7;
    localparam int unsigned NO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [6:0]    pi_out;
    logic [3:0]    po_exact;
    logic [3:0]    po_approx;
    logic          busy;
    logic          done;
    logic [7:0]    mismatch_cnt;
    logic [9:0]    hamming_sum;
    logic [10:0]   abs_err_sum;
    logic [3:0]    max_abs_err;

    int            mode;
    int            n_cmp = 0;
    int            n_fail = 0;

    partition_sweep_err #(.NI(NI), .NO(NO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pi_out       (pi_out),
        .po_exact     (po_exact),
        .po_approx    (po_approx),
        .busy         (busy),
        .done         (done),
        .mismatch_cnt (mismatch_cnt),
        .hamming_sum  (hamming_sum),
        .abs_err_sum  (abs_err_sum),
        .max_abs_err  (max_abs_err)
    );

    always #5 clk = ~clk;

    // Combinational partition models selected by mode.
    always_comb begin
        logic [3:0] sum4;
        sum4 = pi_out[3:0] + {1'b0, pi_out[6:4]};
        po_exact  = sum4;
        po_approx = sum4;
        case (mode)
            1: po_approx = sum4 ^ 4'b0001;
            2: begin po_exact = pi_out[3:0]; po_approx = 4'd0; end
            3: po_approx = (pi_out == 7'h7F) ? (sum4 ^ 4'b1000) : sum4;
            4: begin po_exact = 4'd0; po_approx = pi_out[3:0]; end
            default: ;
        endcase
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int mode;
        int mm;
        int hs;
        int as;
        int mx;
    } vec_t;

    vec_t vecs[5];
    int   cyc;
    int   pulses;
    int   d1;
    int   d2;

    initial begin
        vecs[0] = '{0,   0,   0,   0,  0};
        vecs[1] = '{1, 128, 128, 128,  1};
        vecs[2] = '{2, 120, 256, 960, 15};
        vecs[3] = '{3,   1,   1,   8,  8};
        vecs[4] = '{4, 120, 256, 960, 15};

        mode  = 0;
        start = 1'b0;
        rst   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_pi", int'(pi_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_mm", int'(mismatch_cnt), 0);
        check("rst_abs", int'(abs_err_sum), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 5; t++) begin
            mode = vecs[t].mode;
            @(negedge clk);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc = 0;
            check("busy_after_start", int'(busy), 1);
            check("pi_after_start", int'(pi_out), 0);
            while (cyc < 400 && !done) begin
                // Stray start mid-sweep must not restart or queue.
                start = (cyc == 50);
                @(posedge clk);
                #1;
                cyc++;
            end
            start = 1'b0;
            check("done_cycle", cyc, 256);
            check("fin_pi", int'(pi_out), 127);
            check("fin_busy", int'(busy), 0);
            check("mismatch_cnt", int'(mismatch_cnt), vecs[t].mm);
            check("hamming_sum", int'(hamming_sum), vecs[t].hs);
            check("abs_err_sum", int'(abs_err_sum), vecs[t].as);
            check("max_abs_err", int'(max_abs_err), vecs[t].mx);
            @(posedge clk);
            #1;
            check("done_one_cycle", int'(done), 0);
            repeat (3) @(posedge clk);
            #1;
            check("idle_busy", int'(busy), 0);
            check("hold_mm", int'(mismatch_cnt), vecs[t].mm);
            check("hold_abs", int'(abs_err_sum), vecs[t].as);
        end

        // Reset mid-sweep: outputs clear asynchronously, no done follows.
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("mid_pi", int'(pi_out), 50);
        check("mid_busy", int'(busy), 1);
        check("mid_mm", int'(mismatch_cnt), 50);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", int'(busy), 0);
        check("arst_pi", int'(pi_out), 0);
        check("arst_mm", int'(mismatch_cnt), 0);
        check("arst_hs", int'(hamming_sum), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        check("no_done_after_rst", pulses, 0);

        mode = 2;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (cyc < 400 && !done) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("post_rst_done_cycle", cyc, 256);
        check("post_rst_mm", int'(mismatch_cnt), 120);
        check("post_rst_abs", int'(abs_err_sum), 960);

        // Start held high: back-to-back sweeps every 258 cycles.
        repeat (2) @(posedge clk);
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        pulses = 0;
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 600; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                if (d1 < 0) d1 = c;
                else if (d2 < 0) d2 = c;
            end
            if (c == 256) check("held_mm_256", int'(mismatch_cnt), 128);
            if (c == 257) check("held_busy_257", int'(busy), 0);
            if (c == 257) check("held_mm_257", int'(mismatch_cnt), 128);
            if (c == 258) check("held_clear_258", int'(mismatch_cnt), 0);
            if (c == 258) check("held_busy_258", int'(busy), 1);
        end
        start = 1'b0;
        check("held_pulses", pulses, 2);
        check("held_done1", d1, 256);
        check("held_done2", d2, 514);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
